// File: rtl/string_ctrl.sv
// string_ctrl: arbitrates two requesters and streams framed characters into a shared recognizer.
// Optional STRING_CTRL_STATS_EN adds ok_cnt/bad_cnt frame statistics outputs.
module string_ctrl #(
    parameter logic [7:0] TERM    = 8'h3B,
    parameter int         MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req0_vld,
    input  logic [7:0] req0_char,
    input  logic       req1_vld,
    input  logic [7:0] req1_char,
    output logic       req0_rdy,
    output logic       req1_rdy,
    output logic       rec_clr,
    output logic       rec_en,
    output logic [7:0] rec_in,
    input  logic       rec_out,
    output logic       res_vld,
    output logic       res_id,
    output logic       res_ok,
    output logic       res_abort,
`ifdef STRING_CTRL_STATS_EN
    output logic [7:0] ok_cnt,
    output logic [7:0] bad_cnt,
`endif
    output logic       busy
);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        EVAL,
        REPORT
    } state_t;

    state_t        r_state;
    logic          r_owner;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_res_vld;
    logic          r_res_id;
    logic          r_res_ok;
    logic          r_res_abort;

    logic          w_stream;
    logic          w_vld;
    logic [7:0]    w_char;
    logic          w_is_term;
    logic          w_full;
    logic          w_grant;

    assign w_stream  = (r_state == STREAM) && !clr;
    assign w_vld     = r_owner ? req1_vld : req0_vld;
    assign w_char    = r_owner ? req1_char : req0_char;
    assign w_is_term = (w_char == TERM);
    assign w_full    = (r_cnt == CW'(MAX_LEN));
    // On a tie the side not granted last wins; otherwise the lone requester.
    assign w_grant   = (req0_vld && req1_vld) ? !r_last : req1_vld;

    assign req0_rdy  = w_stream && !r_owner;
    assign req1_rdy  = w_stream && r_owner;
    assign rec_clr   = clr || (r_state == IDLE);
    assign rec_en    = w_stream && w_vld && !w_is_term && !w_full;
    assign rec_in    = w_char;
    assign busy      = (r_state != IDLE);

    assign res_vld   = r_res_vld;
    assign res_id    = r_res_id;
    assign res_ok    = r_res_ok;
    assign res_abort = r_res_abort;

`ifdef STRING_CTRL_STATS_EN
    logic [7:0] r_ok_cnt;
    logic [7:0] r_bad_cnt;

    assign ok_cnt  = r_ok_cnt;
    assign bad_cnt = r_bad_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_ok_cnt  <= 8'd0;
            r_bad_cnt <= 8'd0;
        end else if (r_state == REPORT) begin
            if (r_res_ok) r_ok_cnt <= r_ok_cnt + 8'd1;
            else          r_bad_cnt <= r_bad_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            r_res_vld   <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_ok    <= 1'b0;
            r_res_abort <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (req0_vld || req1_vld) begin
                        r_owner <= w_grant;
                        r_cnt   <= '0;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (!w_vld) begin
                        r_res_ok    <= 1'b0;
                        r_res_abort <= 1'b1;
                        r_res_id    <= r_owner;
                        r_res_vld   <= 1'b1;
                        r_state     <= REPORT;
                    end else if (w_is_term) begin
                        if (r_cnt == '0) begin
                            r_res_ok    <= 1'b0;
                            r_res_abort <= 1'b0;
                            r_res_id    <= r_owner;
                            r_res_vld   <= 1'b1;
                            r_state     <= REPORT;
                        end else begin
                            r_state <= EVAL;
                        end
                    end else if (w_full) begin
                        // Overflow char is swallowed so the requester is not stalled.
                        r_res_ok    <= 1'b0;
                        r_res_abort <= 1'b1;
                        r_res_id    <= r_owner;
                        r_res_vld   <= 1'b1;
                        r_state     <= REPORT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    r_res_ok    <= rec_out;
                    r_res_abort <= 1'b0;
                    r_res_id    <= r_owner;
                    r_res_vld   <= 1'b1;
                    r_state     <= REPORT;
                end
                REPORT: begin
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_string_ctrl.sv
// tb_string_ctrl: vector table, corner sequences and randomized frames vs a frame-level model.
// A digits-only recognizer model drives rec_out.
module tb_string_ctrl;
    localparam logic [7:0] TERM = 8'h3B;

    logic       clk = 1'b0;
    logic       clr;
    logic       drv_v [2];
    logic [7:0] drv_c [2];
    logic       req0_vld, req1_vld;
    logic [7:0] req0_char, req1_char;
    logic       req0_rdy, req1_rdy;
    logic       rec_clr, rec_en, rec_out;
    logic [7:0] rec_in;
    logic       res_vld, res_id, res_ok, res_abort, busy;
`ifdef STRING_CTRL_STATS_EN
    logic [7:0] ok_cnt, bad_cnt;
`endif

    assign req0_vld  = drv_v[0];
    assign req1_vld  = drv_v[1];
    assign req0_char = drv_c[0];
    assign req1_char = drv_c[1];

    always #5 clk = ~clk;

    string_ctrl dut (
        .clk(clk), .clr(clr),
        .req0_vld(req0_vld), .req0_char(req0_char),
        .req1_vld(req1_vld), .req1_char(req1_char),
        .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
        .rec_clr(rec_clr), .rec_en(rec_en), .rec_in(rec_in),
        .rec_out(rec_out),
        .res_vld(res_vld), .res_id(res_id),
        .res_ok(res_ok), .res_abort(res_abort),
`ifdef STRING_CTRL_STATS_EN
        .ok_cnt(ok_cnt), .bad_cnt(bad_cnt),
`endif
        .busy(busy)
    );

    // Recognizer: accepts when every consumed character is a decimal digit.
    logic r_digits;
    always @(posedge clk) begin
        if (rec_clr)     r_digits <= 1'b1;
        else if (rec_en) r_digits <= r_digits && (rec_in >= 8'h30) && (rec_in <= 8'h39);
    end
    assign rec_out = r_digits;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // eo = {rdy0, rdy1, rec_en, rec_clr, res_vld, busy}; er = {id, ok, abort}
    typedef struct {
        logic       cl;
        logic       v0;
        logic [7:0] c0;
        logic       v1;
        logic [7:0] c1;
        logic [5:0] eo;
        logic [2:0] er;
    } vec_t;

    function automatic vec_t mk(logic cl, logic v0, logic [7:0] c0, logic v1,
                                logic [7:0] c1, logic [5:0] eo, logic [2:0] er);
        vec_t t;
        t.cl = cl; t.v0 = v0; t.c0 = c0; t.v1 = v1; t.c1 = c1;
        t.eo = eo; t.er = er;
        return t;
    endfunction

    typedef struct { logic v; logic [7:0] c; } step_t;
    typedef struct { logic ok; logic ab; int nen; } res_t;

    step_t plan [2][$];
    res_t  expq [2][$];
    int    nen;
    int    ok_exp = 0;
    int    bad_exp = 0;

    task automatic gen_frame(input int n);
        int    kind, len, idle;
        logic  alld;
        logic [7:0] ch;
        res_t  r;
        kind = $urandom_range(0, 9);
        idle = $urandom_range(0, 2);
        for (int i = 0; i < idle; i++) plan[n].push_back('{1'b0, 8'h00});
        if (kind <= 6) len = ($urandom_range(0, 7) == 0) ? 32 : $urandom_range(0, 6);
        else if (kind <= 8) len = $urandom_range(1, 6);
        else len = 33;
        alld = 1'b1;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 4) != 0) ch = 8'h30 + 8'($urandom_range(0, 9));
            else ch = 8'h41 + 8'($urandom_range(0, 25));
            if (ch < 8'h30 || ch > 8'h39) alld = 1'b0;
            plan[n].push_back('{1'b1, ch});
        end
        if (kind <= 6) begin
            plan[n].push_back('{1'b1, TERM});
            r.ok = (len > 0) && alld; r.ab = 1'b0; r.nen = len;
        end else if (kind <= 8) begin
            plan[n].push_back('{1'b0, 8'h00});
            r.ok = 1'b0; r.ab = 1'b1; r.nen = len;
        end else begin
            r.ok = 1'b0; r.ab = 1'b1; r.nen = 32;
        end
        expq[n].push_back(r);
    endtask

    task automatic run_plan(input int budget);
        logic hs [2];
        res_t e;
        int   left;
        nen = 0;
        for (int n = 0; n < 2; n++) begin
            drv_v[n] = (plan[n].size() > 0) ? plan[n][0].v : 1'b0;
            drv_c[n] = (plan[n].size() > 0) ? plan[n][0].c : 8'h00;
        end
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (rec_en) nen++;
            if (res_vld) begin
                if (expq[res_id].size() == 0) begin
                    check("rand_unexpected_res", 32'd1, 32'd0);
                end else begin
                    e = expq[res_id].pop_front();
                    check($sformatf("rand_res_id%0d", res_id),
                          {res_ok, res_abort, 8'(nen)}, {e.ok, e.ab, 8'(e.nen)});
                    if (e.ok) ok_exp++; else bad_exp++;
                end
                nen = 0;
            end
            hs[0] = req0_vld && req0_rdy;
            hs[1] = req1_vld && req1_rdy;
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (plan[n].size() > 0 && (!plan[n][0].v || hs[n])) void'(plan[n].pop_front());
                drv_v[n] = (plan[n].size() > 0) ? plan[n][0].v : 1'b0;
                drv_c[n] = (plan[n].size() > 0) ? plan[n][0].c : 8'h00;
            end
            if (plan[0].size() + plan[1].size() + expq[0].size() + expq[1].size() == 0) break;
        end
        left = plan[0].size() + plan[1].size() + expq[0].size() + expq[1].size();
        check("rand_drain", left, 0);
        for (int n = 0; n < 2; n++) begin
            plan[n].delete();
            expq[n].delete();
        end
    endtask

    vec_t tbl [29];
    int   hs_cnt, pulses, seen, nres;

    initial begin
        clr = 1'b1;
        drv_v[0] = 1'b0; drv_v[1] = 1'b0;
        drv_c[0] = 8'h00; drv_c[1] = 8'h00;

        tbl[0]  = mk(1, 1, 8'h39, 0, 8'h00, 6'b000100, 3'b000);
        tbl[1]  = mk(0, 1, 8'h39, 0, 8'h00, 6'b000100, 3'b000);
        tbl[2]  = mk(0, 1, 8'h39, 0, 8'h00, 6'b101001, 3'b000);
        tbl[3]  = mk(0, 1, 8'h39, 0, 8'h00, 6'b101001, 3'b000);
        tbl[4]  = mk(0, 1, 8'h39, 0, 8'h00, 6'b101001, 3'b000);
        tbl[5]  = mk(0, 1, TERM,  0, 8'h00, 6'b100001, 3'b000);
        tbl[6]  = mk(0, 0, 8'h00, 0, 8'h00, 6'b000001, 3'b000);
        tbl[7]  = mk(0, 0, 8'h00, 0, 8'h00, 6'b000011, 3'b010);
        tbl[8]  = mk(0, 0, 8'h00, 0, 8'h00, 6'b000100, 3'b000);
        tbl[9]  = mk(0, 0, 8'h00, 1, 8'h31, 6'b000100, 3'b000);
        tbl[10] = mk(0, 0, 8'h00, 1, 8'h31, 6'b011001, 3'b000);
        tbl[11] = mk(0, 0, 8'h00, 0, 8'h00, 6'b010001, 3'b000);
        tbl[12] = mk(0, 0, 8'h00, 0, 8'h00, 6'b000011, 3'b101);
        tbl[13] = mk(0, 0, 8'h00, 0, 8'h00, 6'b000100, 3'b000);
        tbl[14] = mk(0, 1, TERM,  0, 8'h00, 6'b000100, 3'b000);
        tbl[15] = mk(0, 1, TERM,  0, 8'h00, 6'b100001, 3'b000);
        tbl[16] = mk(0, 0, 8'h00, 0, 8'h00, 6'b000011, 3'b000);
        tbl[17] = mk(0, 0, 8'h00, 0, 8'h00, 6'b000100, 3'b000);
        tbl[18] = mk(1, 1, TERM,  1, TERM,  6'b000100, 3'b000);
        tbl[19] = mk(0, 1, TERM,  1, TERM,  6'b000100, 3'b000);
        tbl[20] = mk(0, 1, TERM,  1, TERM,  6'b100001, 3'b000);
        tbl[21] = mk(0, 1, TERM,  1, TERM,  6'b000011, 3'b000);
        tbl[22] = mk(0, 1, TERM,  1, TERM,  6'b000100, 3'b000);
        tbl[23] = mk(0, 1, TERM,  1, TERM,  6'b010001, 3'b000);
        tbl[24] = mk(0, 1, TERM,  1, TERM,  6'b000011, 3'b100);
        tbl[25] = mk(0, 1, TERM,  1, TERM,  6'b000100, 3'b000);
        tbl[26] = mk(0, 1, TERM,  1, TERM,  6'b100001, 3'b000);
        tbl[27] = mk(0, 1, TERM,  1, TERM,  6'b000011, 3'b000);
        tbl[28] = mk(0, 0, 8'h00, 0, 8'h00, 6'b000100, 3'b000);

        repeat (2) @(posedge clk);
        #1;
        check("reset_res", {res_vld, res_id, res_ok, res_abort, busy}, 5'b0);

        for (int i = 0; i < 29; i++) begin
            clr = tbl[i].cl;
            drv_v[0] = tbl[i].v0; drv_c[0] = tbl[i].c0;
            drv_v[1] = tbl[i].v1; drv_c[1] = tbl[i].c1;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i),
                  {req0_rdy, req1_rdy, rec_en, rec_clr, res_vld, busy}, tbl[i].eo);
            if (tbl[i].eo[1])
                check($sformatf("vec%0d_res", i), {res_id, res_ok, res_abort}, tbl[i].er);
            if (tbl[i].eo[3])
                check($sformatf("vec%0d_in", i), rec_in, tbl[i].eo[5] ? tbl[i].c0 : tbl[i].c1);
            @(posedge clk); #1;
        end

        // Overflow: 33 non-terminator chars from requester 0.
        drv_v[0] = 1'b1; drv_c[0] = 8'h41;
        hs_cnt = 0; pulses = 0; seen = -1;
        for (int c = 0; c < 40 && seen < 0; c++) begin
            @(negedge clk);
            if (rec_en) pulses++;
            if (req0_vld && req0_rdy) hs_cnt++;
            if (res_vld) begin
                seen = c;
                check("ovf_res", {res_id, res_ok, res_abort}, 3'b001);
            end
            @(posedge clk); #1;
            if (hs_cnt == 33) drv_v[0] = 1'b0;
        end
        drv_v[0] = 1'b0;
        check("ovf_pulses", pulses, 32);
        check("ovf_latency", seen, 34);

        // Clear asserted in the middle of a frame.
        drv_v[1] = 1'b1; drv_c[1] = 8'h35;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_stream_rdy1", req1_rdy, 1'b1);
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk);
        check("clr_hold_ctl", {req0_rdy, req1_rdy, rec_en, rec_clr}, 4'b0001);
        @(posedge clk); #1;
        clr = 1'b0; drv_v[1] = 1'b0;
        @(negedge clk);
        check("clr_next_idle", {busy, rec_clr}, 2'b01);
        nres = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (res_vld) nres++;
        end
        check("clr_no_res", nres, 0);

        // Randomized frames against the frame-level model.
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int f = 0; f < 30; f++) begin
            gen_frame(0);
            gen_frame(1);
        end
        run_plan(30000);

`ifdef STRING_CTRL_STATS_EN
        check("stats_ok", ok_cnt, 8'(ok_exp));
        check("stats_bad", bad_cnt, 8'(bad_exp));
        for (int f = 0; f < 256; f++) begin
            res_t r;
            plan[0].push_back('{1'b1, 8'h35});
            plan[0].push_back('{1'b1, TERM});
            r.ok = 1'b1; r.ab = 1'b0; r.nen = 1;
            expq[0].push_back(r);
        end
        run_plan(5000);
        check("stats_wrap_ok", ok_cnt, 8'(ok_exp));
        check("stats_wrap_bad", bad_cnt, 8'(bad_exp));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
